// File: rtl/wb_write_arbiter.sv
// Writeback arbiter: merges in-order pipeline (P) and long-latency unit (X) writes into one RF write port.
// Latency: granted request appears on wr_* exactly one cycle after grant (registered).
// Backpressure: P wins by default; X forced after STARVE_LIMIT lost cycles, stalling P via p_stall_o.
//
// Ports:
//   clk, reset        - sole clock; synchronous active-low reset
//   p_valid_i/regno/val, p_stall_o   - pipeline WB request and its hold signal
//   x_valid_i/regno/val, x_ready_o   - long-latency request, valid/ready handshake
//   wr_en_o/wr_regno_o/wr_val_o      - registered register-file write port
//   stall_cnt_o                      - free-running count of cycles with p_stall_o=1
module wb_write_arbiter #(
  parameter int DBITS        = 32,
  parameter int REGNOBITS    = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 p_valid_i,
  input  logic [REGNOBITS-1:0] p_regno_i,
  input  logic [DBITS-1:0]     p_val_i,
  output logic                 p_stall_o,
  input  logic                 x_valid_i,
  input  logic [REGNOBITS-1:0] x_regno_i,
  input  logic [DBITS-1:0]     x_val_i,
  output logic                 x_ready_o,
  output logic                 wr_en_o,
  output logic [REGNOBITS-1:0] wr_regno_o,
  output logic [DBITS-1:0]     wr_val_o,
  output logic [31:0]          stall_cnt_o
);

  typedef enum logic {NORMAL = 1'b0, FORCE = 1'b1} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state;
  logic [3:0] wait_cnt;
  logic [3:0] wait_nxt;

  logic p_grant;
  logic x_grant;

  // Grant decision depends only on state and p_valid_i so x_ready_o never
  // combinationally loops back through x_valid_i. Nothing is granted in reset.
  always_comb begin
    x_ready_o = 1'b0;
    p_stall_o = 1'b0;
    p_grant   = 1'b0;
    if (reset) begin
      if (state == FORCE) begin
        x_ready_o = 1'b1;
        p_stall_o = p_valid_i;
      end else begin
        x_ready_o = ~p_valid_i;
        p_grant   = p_valid_i;
      end
    end
  end

  assign x_grant  = x_valid_i & x_ready_o;
  assign wait_nxt = 4'(wait_cnt + 4'd1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= NORMAL;
      wait_cnt    <= 4'd0;
      wr_en_o     <= 1'b0;
      wr_regno_o  <= '0;
      wr_val_o    <= '0;
      stall_cnt_o <= 32'd0;
    end else begin
      // Starvation tracking: only a held-but-refused X request counts.
      // X dropping valid or completing a handshake starts the count over.
      if (x_grant || !x_valid_i) begin
        state    <= NORMAL;
        wait_cnt <= 4'd0;
      end else if (state == NORMAL) begin
        wait_cnt <= wait_nxt;
        if (wait_nxt == LIMIT) begin
          state <= FORCE;
        end
      end

      // Single RF write port; regno 0 is the hardwired zero register, so the
      // transfer completes but the write itself is suppressed.
      if (x_grant) begin
        wr_en_o    <= (x_regno_i != '0);
        wr_regno_o <= x_regno_i;
        wr_val_o   <= x_val_i;
      end else if (p_grant) begin
        wr_en_o    <= (p_regno_i != '0);
        wr_regno_o <= p_regno_i;
        wr_val_o   <= p_val_i;
      end else begin
        wr_en_o    <= 1'b0;
      end

      if (p_stall_o) begin
        stall_cnt_o <= stall_cnt_o + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
module tb_wb_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p_valid_i;
  logic [4:0]  p_regno_i;
  logic [31:0] p_val_i;
  logic        p_stall_o;
  logic        x_valid_i;
  logic [4:0]  x_regno_i;
  logic [31:0] x_val_i;
  logic        x_ready_o;
  logic        wr_en_o;
  logic [4:0]  wr_regno_o;
  logic [31:0] wr_val_o;
  logic [31:0] stall_cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_write_arbiter #(.DBITS(32), .REGNOBITS(5), .STARVE_LIMIT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .p_valid_i   (p_valid_i),
    .p_regno_i   (p_regno_i),
    .p_val_i     (p_val_i),
    .p_stall_o   (p_stall_o),
    .x_valid_i   (x_valid_i),
    .x_regno_i   (x_regno_i),
    .x_val_i     (x_val_i),
    .x_ready_o   (x_ready_o),
    .wr_en_o     (wr_en_o),
    .wr_regno_o  (wr_regno_o),
    .wr_val_o    (wr_val_o),
    .stall_cnt_o (stall_cnt_o)
  );

  // One record per clock: inputs driven before the edge, combinational
  // outputs expected before the edge, registered outputs expected after it.
  typedef struct packed {
    logic        rst;
    logic        pv;
    logic [4:0]  pr;
    logic [31:0] pd;
    logic        xv;
    logic [4:0]  xr;
    logic [31:0] xd;
    logic        e_xr;
    logic        e_ps;
    logic        e_en;
    logic [4:0]  e_r;
    logic [31:0] e_d;
    logic [31:0] e_sc;
  } vec_t;

  localparam int NV = 24;
  vec_t tbl [NV];

  function automatic vec_t mk(logic rst, logic pv, logic [4:0] pr, logic [31:0] pd,
                              logic xv, logic [4:0] xr, logic [31:0] xd,
                              logic e_xr, logic e_ps, logic e_en, logic [4:0] e_r,
                              logic [31:0] e_d, logic [31:0] e_sc);
    vec_t v;
    v.rst = rst; v.pv = pv; v.pr = pr; v.pd = pd;
    v.xv = xv; v.xr = xr; v.xd = xd;
    v.e_xr = e_xr; v.e_ps = e_ps; v.e_en = e_en;
    v.e_r = e_r; v.e_d = e_d; v.e_sc = e_sc;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s [%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic pv, input logic [4:0] pr, input logic [31:0] pd,
                       input logic xv, input logic [4:0] xr, input logic [31:0] xd);
    reset = rst; p_valid_i = pv; p_regno_i = pr; p_val_i = pd;
    x_valid_i = xv; x_regno_i = xr; x_val_i = xd;
  endtask

  initial begin
    //           rst pv pr     pd            xv xr     xd            xr ps en r      d             sc
    // reset held two cycles with both requesters active
    tbl[0]  = mk(0, 1, 5'd5,  32'h000000A5, 1, 5'd7,  32'h00001234, 0, 0, 0, 5'd0,  32'h0,        0);
    tbl[1]  = mk(0, 1, 5'd5,  32'h000000A5, 1, 5'd7,  32'h00001234, 0, 0, 0, 5'd0,  32'h0,        0);
    // P only, then X only, then idle (regno/val hold)
    tbl[2]  = mk(1, 1, 5'd5,  32'h000000A5, 0, 5'd0,  32'h0,        0, 0, 1, 5'd5,  32'h000000A5, 0);
    tbl[3]  = mk(1, 0, 5'd0,  32'h0,        1, 5'd7,  32'h00001234, 1, 0, 1, 5'd7,  32'h00001234, 0);
    tbl[4]  = mk(1, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 0, 0, 5'd7,  32'h00001234, 0);
    // starvation: X held, P wins four times, then X forced while P stalls
    tbl[5]  = mk(1, 1, 5'd1,  32'h00000011, 1, 5'd9,  32'h00000099, 0, 0, 1, 5'd1,  32'h00000011, 0);
    tbl[6]  = mk(1, 1, 5'd2,  32'h00000022, 1, 5'd9,  32'h00000099, 0, 0, 1, 5'd2,  32'h00000022, 0);
    tbl[7]  = mk(1, 1, 5'd3,  32'h00000033, 1, 5'd9,  32'h00000099, 0, 0, 1, 5'd3,  32'h00000033, 0);
    tbl[8]  = mk(1, 1, 5'd4,  32'h00000044, 1, 5'd9,  32'h00000099, 0, 0, 1, 5'd4,  32'h00000044, 0);
    tbl[9]  = mk(1, 1, 5'd5,  32'h00000055, 1, 5'd9,  32'h00000099, 1, 1, 1, 5'd9,  32'h00000099, 1);
    tbl[10] = mk(1, 1, 5'd5,  32'h00000055, 0, 5'd0,  32'h0,        0, 0, 1, 5'd5,  32'h00000055, 1);
    // regno 0 from X and from P: transfer happens, write suppressed
    tbl[11] = mk(1, 0, 5'd0,  32'h0,        1, 5'd0,  32'h0000DEAD, 1, 0, 0, 5'd0,  32'h0000DEAD, 1);
    tbl[12] = mk(1, 1, 5'd0,  32'h0000BEEF, 0, 5'd0,  32'h0,        0, 0, 0, 5'd0,  32'h0000BEEF, 1);
    // drive into FORCE again, then reset there
    tbl[13] = mk(1, 1, 5'd1,  32'h00000001, 1, 5'd8,  32'h00000088, 0, 0, 1, 5'd1,  32'h00000001, 1);
    tbl[14] = mk(1, 1, 5'd2,  32'h00000002, 1, 5'd8,  32'h00000088, 0, 0, 1, 5'd2,  32'h00000002, 1);
    tbl[15] = mk(1, 1, 5'd3,  32'h00000003, 1, 5'd8,  32'h00000088, 0, 0, 1, 5'd3,  32'h00000003, 1);
    tbl[16] = mk(1, 1, 5'd4,  32'h00000004, 1, 5'd8,  32'h00000088, 0, 0, 1, 5'd4,  32'h00000004, 1);
    tbl[17] = mk(0, 1, 5'd4,  32'h00000004, 1, 5'd8,  32'h00000088, 0, 0, 0, 5'd0,  32'h0,        0);
    // after release P goes first; X forced only after four more lost cycles
    tbl[18] = mk(1, 1, 5'd10, 32'h000000A0, 1, 5'd8,  32'h00000088, 0, 0, 1, 5'd10, 32'h000000A0, 0);
    tbl[19] = mk(1, 1, 5'd11, 32'h000000B0, 1, 5'd8,  32'h00000088, 0, 0, 1, 5'd11, 32'h000000B0, 0);
    tbl[20] = mk(1, 1, 5'd12, 32'h000000C0, 1, 5'd8,  32'h00000088, 0, 0, 1, 5'd12, 32'h000000C0, 0);
    tbl[21] = mk(1, 1, 5'd13, 32'h000000D0, 1, 5'd8,  32'h00000088, 0, 0, 1, 5'd13, 32'h000000D0, 0);
    tbl[22] = mk(1, 1, 5'd14, 32'h000000E0, 1, 5'd8,  32'h00000088, 1, 1, 1, 5'd8,  32'h00000088, 1);
    tbl[23] = mk(1, 1, 5'd14, 32'h000000E0, 0, 5'd0,  32'h0,        0, 0, 1, 5'd14, 32'h000000E0, 1);

    drive(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].pv, tbl[i].pr, tbl[i].pd, tbl[i].xv, tbl[i].xr, tbl[i].xd);
      #1;
      chk("x_ready", i, 32'(x_ready_o), 32'(tbl[i].e_xr));
      chk("p_stall", i, 32'(p_stall_o), 32'(tbl[i].e_ps));
      @(posedge clk);
      #1;
      chk("wr_en",     i, 32'(wr_en_o),    32'(tbl[i].e_en));
      chk("wr_regno",  i, 32'(wr_regno_o), 32'(tbl[i].e_r));
      chk("wr_val",    i, wr_val_o,        tbl[i].e_d);
      chk("stall_cnt", i, stall_cnt_o,     tbl[i].e_sc);
    end

    // X dropping valid mid-wait must restart the starvation count:
    // 3 lost cycles, one idle X cycle, then a full 4 more lost cycles before FORCE.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1, 1, 5'd20, 32'(i), 1, 5'd21, 32'h00000210);
      #1;
      chk("drop_pre_x_ready", i, 32'(x_ready_o), 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    drive(1, 1, 5'd20, 32'h3, 0, 5'd0, 32'h0);
    #1;
    chk("drop_gap_x_ready", 0, 32'(x_ready_o), 32'd0);
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1, 1, 5'd20, 32'(i + 4), 1, 5'd21, 32'h00000210);
      #1;
      chk("drop_post_x_ready", i, 32'(x_ready_o), 32'd0);
      chk("drop_post_p_stall", i, 32'(p_stall_o), 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    drive(1, 1, 5'd20, 32'h8, 1, 5'd21, 32'h00000210);
    #1;
    chk("drop_force_x_ready", 0, 32'(x_ready_o), 32'd1);
    chk("drop_force_p_stall", 0, 32'(p_stall_o), 32'd1);
    @(posedge clk);
    #1;
    chk("drop_force_wr_regno", 0, 32'(wr_regno_o), 32'd21);
    chk("drop_force_wr_val",   0, wr_val_o,        32'h00000210);
    chk("drop_force_stall_cnt", 0, stall_cnt_o,    32'd2);

    // FORCE with P idle: X accepted, no stall counted
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1, 1, 5'd22, 32'(i), 1, 5'd23, 32'h00000230);
      @(posedge clk);
    end
    @(negedge clk);
    drive(1, 0, 5'd0, 32'h0, 1, 5'd23, 32'h00000230);
    #1;
    chk("force_idle_x_ready", 0, 32'(x_ready_o), 32'd1);
    chk("force_idle_p_stall", 0, 32'(p_stall_o), 32'd0);
    @(posedge clk);
    #1;
    chk("force_idle_wr_regno",  0, 32'(wr_regno_o), 32'd23);
    chk("force_idle_stall_cnt", 0, stall_cnt_o,     32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
